// File: rtl/full_adder_pkg.sv
// Bit-level helpers shared by the full adder cell and its users.
package full_adder_pkg;

  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  // Majority of the three inputs is the carry out.
  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit combinational full adder cell: a + b + c -> {co, s}.
module full_adder_cell
  import full_adder_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = fa_sum(a_i, b_i, c_i);
  assign co_o = fa_carry(a_i, b_i, c_i);

endmodule

// File: rtl/full_adder.sv
// Ripple-carry adder of WIDTH full adder cells with an optional output register
// stage and a one-cycle valid tracker.
module full_adder #(
  parameter int unsigned WIDTH   = 1,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;
  logic             valid_q;

  assign carry[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a_i  (A[i]),
      .b_i  (B[i]),
      .c_i  (carry[i]),
      .s_o  (sum_c[i]),
      .co_o (carry[i+1])
    );
  end

  // out_valid is always registered, even when the datapath is combinational.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
    end
  end

  assign out_valid = valid_q;

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    // Result register loads every cycle; consumers qualify it with out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q  <= '0;
        cout_q <= 1'b0;
      end else begin
        sum_q  <= sum_c;
        cout_q <= carry[WIDTH];
      end
    end

    assign Sum  = sum_q;
    assign Cout = cout_q;
  end else begin : g_comb
    assign Sum  = sum_c;
    assign Cout = carry[WIDTH];
  end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: 1-bit registered, 8-bit registered and
// 1-bit combinational builds driven side by side.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic       a1, b1, c1, v1, s1, co1, ov1;
  logic [7:0] a8, b8, s8;
  logic       c8, v8, co8, ov8;
  logic       ac, bc, cc, vc, sc, coc, ovc;

  full_adder #(.WIDTH(1), .REG_OUT(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Cin(c1), .in_valid(v1),
    .Sum(s1), .Cout(co1), .out_valid(ov1)
  );

  full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .Cin(c8), .in_valid(v8),
    .Sum(s8), .Cout(co8), .out_valid(ov8)
  );

  full_adder #(.WIDTH(1), .REG_OUT(1'b0)) u_dutc (
    .clk(clk), .rst_n(rst_n), .A(ac), .B(bc), .Cin(cc), .in_valid(vc),
    .Sum(sc), .Cout(coc), .out_valid(ovc)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       a;
    logic       b;
    logic       cin;
    logic [1:0] exp;
  } vec_t;

  vec_t       tbl [8];
  logic [1:0] exp_tbl [8];
  logic [2:0] pat;
  logic       vpat [3];
  logic [2:0] ipat [3];
  logic [7:0] ra, rb;
  logic       rc, rv;
  logic [8:0] rexp;

  initial begin
    exp_tbl = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    for (int i = 0; i < 8; i++) begin
      pat        = 3'(i);
      tbl[i].a   = pat[2];
      tbl[i].b   = pat[1];
      tbl[i].cin = pat[0];
      tbl[i].exp = exp_tbl[i];
    end
    vpat = '{1'b1, 1'b0, 1'b1};
    ipat = '{3'b011, 3'b111, 3'b100};

    rst_n = 1'b0;
    {a1, b1, c1, v1} = '0;
    {a8, b8, c8, v8} = '0;
    {ac, bc, cc, vc} = '0;

    // Reset values before any clock edge.
    #2;
    check("rst_init_sum1", {co1, s1}, 2'b00);
    check("rst_init_ov1", ov1, 1'b0);
    check("rst_init_ov8", ov8, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;

    // Load a non-zero result, then assert reset mid-cycle.
    {a1, b1, c1, v1} = 4'b1111;
    a8 = 8'hA5; b8 = 8'h3C; c8 = 1'b1; v8 = 1'b1;
    tick();
    check("pre_rst_sum1", {co1, s1}, 2'b11);
    check("pre_rst_ov1", ov1, 1'b1);
    check("pre_rst_sum8", {co8, s8}, 9'h0E2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_sum1", {co1, s1}, 2'b00);
    check("async_rst_ov1", ov1, 1'b0);
    check("async_rst_sum8", {co8, s8}, 9'h000);
    check("async_rst_ov8", ov8, 1'b0);
    tick();
    check("held_rst_sum1", {co1, s1}, 2'b00);
    check("held_rst_ov1", ov1, 1'b0);

    // First post-reset edge samples in_valid=0, so out_valid stays low.
    rst_n = 1'b1;
    v1 = 1'b0;
    tick();
    check("post_rst_ov_low", ov1, 1'b0);
    v1 = 1'b1;
    tick();
    check("post_rst_ov_high", ov1, 1'b1);

    // Exhaustive 1-bit truth table.
    for (int i = 0; i < 8; i++) begin
      a1 = tbl[i].a; b1 = tbl[i].b; c1 = tbl[i].cin; v1 = 1'b1;
      tick();
      check($sformatf("tt_%0d", i), {co1, s1}, tbl[i].exp);
      check($sformatf("tt_ov_%0d", i), ov1, 1'b1);
    end

    // Valid tracking 1,0,1 while data keeps flowing.
    for (int i = 0; i < 3; i++) begin
      {a1, b1, c1} = ipat[i];
      v1 = vpat[i];
      tick();
      check($sformatf("vt_ov_%0d", i), ov1, vpat[i]);
      check($sformatf("vt_sum_%0d", i), {co1, s1},
            2'(32'(ipat[i][2]) + 32'(ipat[i][1]) + 32'(ipat[i][0])));
    end

    // 8-bit wrap-around corners.
    a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0; v8 = 1'b1;
    tick();
    check("wrap_ff_01", {co8, s8}, 9'h100);
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    tick();
    check("wrap_ff_ff_1", {co8, s8}, 9'h1FF);
    a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
    tick();
    check("zero", {co8, s8}, 9'h000);

    // Randomised 8-bit against plain integer addition.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rc = 1'($urandom); rv = 1'($urandom);
      a8 = ra; b8 = rb; c8 = rc; v8 = rv;
      rexp = 9'(32'(ra) + 32'(rb) + 32'(rc));
      tick();
      check($sformatf("rand_sum_%0d", i), {co8, s8}, rexp);
      check($sformatf("rand_ov_%0d", i), ov8, rv);
    end

    // Combinational build: Sum follows inputs between edges, out_valid still registered.
    {ac, bc, cc} = 3'b000;
    vc = 1'b1;
    tick();
    check("comb_ov", ovc, 1'b1);
    check("comb_zero", {coc, sc}, 2'b00);
    #2;
    ac = 1'b1;
    #1;
    check("comb_a1", {coc, sc}, 2'b01);
    bc = 1'b1;
    cc = 1'b1;
    #0.5;
    check("comb_111", {coc, sc}, 2'b11);
    vc = 1'b0;
    tick();
    check("comb_ov_low", ovc, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
